// File: rtl/tdc_sweep_gen.sv
// tdc_sweep_gen: start/stop stimulus generator for TDC characterisation.
// Each shot raises start. Each stop[c] then rises at cur_delay + c*ch_spacing
// and stays high for pulse_w cycles. Start falls together with the last stop.
// Shots repeat at max(period, L+1), optionally sweeping the delay shot by shot.
module tdc_sweep_gen #(
  parameter int CNT_W = 16,
  parameter int N_CH  = 4,
  parameter int PW_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  delay_min,
  input  logic [CNT_W-1:0]  delay_max,
  input  logic [CNT_W-1:0]  delay_step,
  input  logic [CNT_W-1:0]  ch_spacing,
  input  logic [CNT_W-1:0]  period,
  input  logic [PW_W-1:0]   pulse_w,
  output logic              start,
  output logic [N_CH-1:0]   stop,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cur_delay,
  output logic [CNT_W-1:0]  shot_count
);

  // Wide enough for cur_delay + (N_CH-1)*ch_spacing + pulse_w plus one guard bit.
  localparam int LW = CNT_W + $clog2(N_CH) + PW_W + 1;

  localparam logic [LW-1:0]    TC_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PW_W-1:0]  PW_ONE  = {{(PW_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_ONCE   = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;
  localparam logic [1:0] MODE_FIXED  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [LW-1:0]    tc_r, tc_s;          // cycles since start rose for this shot
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] dmin_r, dmax_r, step_r, spacing_r, period_r;
  logic [PW_W-1:0]  pw_r;

  logic             latch_s;
  logic [CNT_W-1:0] delay_s, count_s;
  logic             busy_s, done_s, start_s;
  logic [N_CH-1:0]  stop_s;
  logic [LW-1:0]    shot_len_s, period_eff_s, tc_inc_s, rise_s;
  logic [CNT_W:0]   sweep_sum_s;
  logic             sweep_over_s;

  // Shot length, effective period and the sweep increment for the current shot.
  always_comb begin
    shot_len_s = LW'(cur_delay) + (LW'(spacing_r) * LW'(N_CH - 1)) + LW'(pw_r);
    if (LW'(period_r) > shot_len_s) begin
      period_eff_s = LW'(period_r);
    end else begin
      period_eff_s = shot_len_s + TC_ONE;
    end
    tc_inc_s     = tc_r + TC_ONE;
    sweep_sum_s  = {1'b0, cur_delay} + {1'b0, step_r};
    sweep_over_s = (sweep_sum_s > {1'b0, dmax_r});
  end

  // Next-state logic: run acceptance, shot sequencing, sweep update and abort.
  always_comb begin
    state_s = state_r;
    tc_s    = tc_r;
    delay_s = cur_delay;
    count_s = shot_count;
    busy_s  = busy;
    done_s  = 1'b0;
    latch_s = 1'b0;
    if (!enable) begin
      // Abort: drop to IDLE without done; delay and count keep their values.
      state_s = S_IDLE;
      tc_s    = {LW{1'b0}};
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            state_s = S_ARM;
            tc_s    = {LW{1'b0}};
            latch_s = 1'b1;
            delay_s = delay_min;
            count_s = {CNT_W{1'b0}};
            busy_s  = 1'b1;
          end else begin
            busy_s  = 1'b0;
          end
        end
        S_ARM: begin
          state_s = S_PULSE;
          tc_s    = {LW{1'b0}};
        end
        S_PULSE: begin
          tc_s = tc_inc_s;
          if (tc_inc_s >= shot_len_s) begin
            state_s = S_GAP;
            count_s = shot_count + CNT_ONE;
          end else begin
            state_s = S_PULSE;
          end
        end
        S_GAP: begin
          tc_s = tc_inc_s;
          if (tc_inc_s >= period_eff_s) begin
            tc_s = {LW{1'b0}};
            case (mode_r)
              MODE_SINGLE: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
              end
              MODE_ONCE: begin
                if (sweep_over_s) begin
                  state_s = S_IDLE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                end else begin
                  state_s = S_PULSE;
                  delay_s = sweep_sum_s[CNT_W-1:0];
                end
              end
              MODE_CONT: begin
                state_s = S_PULSE;
                if (sweep_over_s) begin
                  delay_s = dmin_r;
                end else begin
                  delay_s = sweep_sum_s[CNT_W-1:0];
                end
              end
              MODE_FIXED: begin
                state_s = S_PULSE;
                delay_s = dmin_r;
              end
              default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
              end
            endcase
          end else begin
            state_s = S_GAP;
          end
        end
        default: begin
          state_s = S_IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // Pulse levels for the next cycle, from the next shot-relative time and delay.
  always_comb begin
    start_s = (state_s == S_PULSE);
    stop_s  = {N_CH{1'b0}};
    rise_s  = {LW{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      rise_s = LW'(delay_s) + (LW'(spacing_r) * LW'(c));
      if (start_s && (tc_s >= rise_s) && (tc_s < (rise_s + LW'(pw_r)))) begin
        stop_s[c] = 1'b1;
      end else begin
        stop_s[c] = 1'b0;
      end
    end
  end

  // FSM state and shot-relative cycle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      tc_r    <= {LW{1'b0}};
    end else begin
      state_r <= state_s;
      tc_r    <= tc_s;
    end
  end

  // Configuration shadow registers, captured once when a run is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_r    <= 2'd0;
      dmin_r    <= {CNT_W{1'b0}};
      dmax_r    <= {CNT_W{1'b0}};
      step_r    <= {CNT_W{1'b0}};
      spacing_r <= {CNT_W{1'b0}};
      period_r  <= {CNT_W{1'b0}};
      pw_r      <= {PW_W{1'b0}};
    end else if (latch_s) begin
      mode_r    <= mode;
      dmin_r    <= delay_min;
      dmax_r    <= delay_max;
      step_r    <= (delay_step == {CNT_W{1'b0}}) ? CNT_ONE : delay_step;
      spacing_r <= ch_spacing;
      period_r  <= period;
      pw_r      <= (pulse_w == {PW_W{1'b0}}) ? PW_ONE : pulse_w;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start      <= 1'b0;
      stop       <= {N_CH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_delay  <= {CNT_W{1'b0}};
      shot_count <= {CNT_W{1'b0}};
    end else begin
      start      <= start_s;
      stop       <= stop_s;
      busy       <= busy_s;
      done       <= done_s;
      cur_delay  <= delay_s;
      shot_count <= count_s;
    end
  end

endmodule
